// File: rtl/auv_rom_arbiter.sv
// Arbitrates the single synchronous bootrom read port between fetch and load; grant is combinational, data returns one cycle later.
// A saturating starvation counter forces a fetch win after STARVE_LIMIT consecutive denied fetch cycles.
module auv_rom_arbiter #(
    parameter int BOOTROM_WIDTH = 10,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     if_req,
    input  logic [BOOTROM_WIDTH-1:0] if_adr,
    output logic                     if_gnt,
    output logic                     if_vld,
    output logic [31:0]              if_dat,
    input  logic                     ls_req,
    input  logic [BOOTROM_WIDTH-1:0] ls_adr,
    output logic                     ls_gnt,
    output logic                     ls_vld,
    output logic [31:0]              ls_dat,
    input  logic                     flush,
    output logic                     if_stall,
    output logic [BOOTROM_WIDTH-1:0] rom_adr,
    input  logic [31:0]              rom_dat
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_e;

    owner_e                   owner_q, owner_d;
    logic [CW-1:0]            starve_cnt_q, starve_cnt_d;
    logic [BOOTROM_WIDTH-1:0] last_adr_q, last_adr_d;
    logic                     force_fetch;

    always_comb begin
        force_fetch = (starve_cnt_q >= CW'(STARVE_LIMIT));
        if_gnt      = if_req & (~ls_req | force_fetch);
        ls_gnt      = ls_req & ~(if_req & force_fetch);
        if_stall    = if_req & ~if_gnt;

        // With no grant the ROM keeps re-reading the last address so its output stays stable.
        if (if_gnt) begin
            rom_adr = if_adr;
        end else if (ls_gnt) begin
            rom_adr = ls_adr;
        end else begin
            rom_adr = last_adr_q;
        end
        last_adr_d = rom_adr;

        owner_d = OWN_NONE;
        if (if_gnt) begin
            owner_d = OWN_IF;
        end else if (ls_gnt) begin
            owner_d = OWN_LS;
        end

        starve_cnt_d = starve_cnt_q;
        if (if_gnt || !if_req) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q < CW'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q      <= OWN_NONE;
            starve_cnt_q <= '0;
            last_adr_q   <= '0;
        end else begin
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            last_adr_q   <= last_adr_d;
        end
    end

    // A redirect must never see a stale fetch word, so flush masks the response in its own cycle.
    assign if_vld = (owner_q == OWN_IF) & ~flush;
    assign ls_vld = (owner_q == OWN_LS);
    assign if_dat = rom_dat;
    assign ls_dat = rom_dat;

endmodule

// File: tb/tb_auv_rom_arbiter.sv
// Bench for auv_rom_arbiter: directed scenarios followed by constrained-random traffic against a cycle-level reference model.
module tb_auv_rom_arbiter;

    localparam int AW    = 10;
    localparam int LIMIT = 4;

    logic          clk;
    logic          rst_n;
    logic          if_req, ls_req, flush;
    logic [AW-1:0] if_adr, ls_adr, rom_adr;
    logic          if_gnt, ls_gnt, if_vld, ls_vld, if_stall;
    logic [31:0]   if_dat, ls_dat, rom_dat;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int            m_wait;
    int            m_pend;      // 0 none, 1 fetch, 2 load
    logic [AW-1:0] m_pend_adr;
    logic [AW-1:0] m_last;
    logic          g_if, g_ls;
    logic          dut_if_gnt_seen;

    auv_rom_arbiter #(.BOOTROM_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_adr(if_adr), .if_gnt(if_gnt), .if_vld(if_vld), .if_dat(if_dat),
        .ls_req(ls_req), .ls_adr(ls_adr), .ls_gnt(ls_gnt), .ls_vld(ls_vld), .ls_dat(ls_dat),
        .flush(flush), .if_stall(if_stall), .rom_adr(rom_adr), .rom_dat(rom_dat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_fn(input logic [AW-1:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    initial rom_dat = 32'h0;
    always @(posedge clk) rom_dat <= rom_fn(rom_adr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wait = 0;
        m_pend = 0;
        m_pend_adr = '0;
        m_last = '0;
        g_if = 1'b0;
        g_ls = 1'b0;
    endtask

    // Called 1 time unit after a rising edge; applies inputs, checks, then advances one cycle.
    task automatic step(input logic ir, input logic [AW-1:0] ia,
                        input logic lr, input logic [AW-1:0] la, input logic fl);
        logic          eg_if, eg_ls, frc, ev_if;
        logic [AW-1:0] eadr;
        if_req = ir; if_adr = ia; ls_req = lr; ls_adr = la; flush = fl;
        #2;
        frc   = (m_wait >= LIMIT);
        eg_if = ir && (!lr || frc);
        eg_ls = lr && !eg_if;
        eadr  = eg_if ? ia : (eg_ls ? la : m_last);
        ev_if = (m_pend == 1) && !fl;
        chk("if_gnt",   32'(if_gnt),   32'(eg_if));
        chk("ls_gnt",   32'(ls_gnt),   32'(eg_ls));
        chk("if_stall", 32'(if_stall), 32'(ir && !eg_if));
        chk("rom_adr",  32'(rom_adr),  32'(eadr));
        chk("if_vld",   32'(if_vld),   32'(ev_if));
        chk("ls_vld",   32'(ls_vld),   32'(m_pend == 2));
        if (ev_if)       chk("if_dat", if_dat, rom_fn(m_pend_adr));
        if (m_pend == 2) chk("ls_dat", ls_dat, rom_fn(m_pend_adr));
        dut_if_gnt_seen = if_gnt;
        @(posedge clk);
        #1;
        m_pend     = eg_if ? 1 : (eg_ls ? 2 : 0);
        m_pend_adr = eadr;
        m_last     = eadr;
        if (ir && !eg_if) m_wait = (m_wait < LIMIT) ? m_wait + 1 : m_wait;
        else              m_wait = 0;
        g_if = eg_if;
        g_ls = eg_ls;
    endtask

    initial begin
        int            first_k;
        logic          r_ir, r_lr, r_fl;
        logic [AW-1:0] r_ia, r_la;

        rst_n = 1'b0; if_req = 1'b0; ls_req = 1'b0; flush = 1'b0;
        if_adr = '0; ls_adr = '0;
        model_reset();
        #3;
        chk("rst_if_vld",  32'(if_vld),  32'h0);
        chk("rst_ls_vld",  32'(ls_vld),  32'h0);
        chk("rst_rom_adr", 32'(rom_adr), 32'h0);
        chk("rst_if_gnt",  32'(if_gnt),  32'h0);
        if_req = 1'b1;
        #1;
        chk("rst_if_gnt_comb", 32'(if_gnt), 32'h1);
        if_req = 1'b0;
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single fetch
        step(1'b1, 10'h005, 1'b0, 10'h000, 1'b0);
        step(1'b0, 10'h005, 1'b0, 10'h000, 1'b0);

        // Contention: load wins
        step(1'b1, 10'h010, 1'b1, 10'h200, 1'b0);
        step(1'b1, 10'h010, 1'b0, 10'h200, 1'b0);
        step(1'b0, 10'h010, 1'b0, 10'h200, 1'b0);

        // Starvation: fetch forced through on the fifth cycle
        first_k = -1;
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 10'h0AB, 1'b1, AW'(10'h100 + k), 1'b0);
            if (dut_if_gnt_seen && first_k < 0) first_k = k;
        end
        chk("starve_first_if_gnt", 32'(first_k), 32'd4);
        step(1'b0, 10'h0AB, 1'b0, 10'h000, 1'b0);

        // Flush with same-cycle redirect fetch
        step(1'b1, 10'h020, 1'b0, 10'h000, 1'b0);
        step(1'b1, 10'h100, 1'b0, 10'h000, 1'b1);
        step(1'b0, 10'h100, 1'b0, 10'h000, 1'b0);

        // Idle hold after a load
        step(1'b0, 10'h000, 1'b1, 10'h033, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 10'h000, 1'b0, 10'h000, 1'b0);

        // Reset mid-operation
        step(1'b0, 10'h000, 1'b1, 10'h044, 1'b0);
        ls_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ls_vld", 32'(ls_vld), 32'h0);
        chk("midrst_if_vld", 32'(if_vld), 32'h0);
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        step(1'b0, 10'h000, 1'b0, 10'h000, 1'b0);

        // Random traffic; stalled requesters hold their request and address
        r_ir = 1'b0; r_lr = 1'b0; r_ia = '0; r_la = '0;
        for (int n = 0; n < 400; n++) begin
            if (!(r_ir && !g_if)) begin
                r_ir = ($urandom_range(0, 3) != 0);
                r_ia = AW'($urandom);
            end
            if (!(r_lr && !g_ls)) begin
                r_lr = ($urandom_range(0, 2) != 0);
                r_la = AW'($urandom);
            end
            r_fl = ($urandom_range(0, 7) == 0);
            step(r_ir, r_ia, r_lr, r_la, r_fl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
